// File: rtl/calc_ctrl_pkg.sv
// Shared definitions for the binary calculator controller front end:
// key-decoder state encoding, the fixed key prefix and the mode codes.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S10    = 3'd2,
    S101   = 3'd3,
    ACTIVE = 3'd4
  } key_state_t;

  // First three key bits, MSB first; the fourth bit selects the mode.
  localparam logic [2:0] KEY_PREFIX = 3'b101;

  localparam logic MODE_BASIC = 1'b0;
  localparam logic MODE_EXT   = 1'b1;

endpackage

// File: rtl/dec_input_key.sv
// Serial access-key decoder. Shifts in one key bit per qualified cycle,
// unlocks on 101x and latches the mode from the final bit. Once unlocked
// the block stays unlocked, ignoring all input, until reset.
module dec_input_key
  import calc_ctrl_pkg::*;
(
  input  logic input_key,
  input  logic valid_cmd,
  input  logic reset,
  input  logic clk,
  output logic active,
  output logic mode
);

  key_state_t state_q, state_d;
  logic       mode_q, mode_d;

  // State and mode registers; reset has priority over any key input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_BASIC;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and mode selection; mode is only written when leaving S101.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (valid_cmd) begin
      unique case (state_q)
        IDLE: begin
          if (input_key == KEY_PREFIX[2]) state_d = S1;
          else                            state_d = IDLE;
        end
        S1: begin
          // A repeated leading 1 restarts the match instead of failing it.
          if (input_key == KEY_PREFIX[1]) state_d = S10;
          else                            state_d = S1;
        end
        S10: begin
          if (input_key == KEY_PREFIX[0]) state_d = S101;
          else                            state_d = IDLE;
        end
        S101: begin
          state_d = ACTIVE;
          mode_d  = input_key ? MODE_EXT : MODE_BASIC;
        end
        ACTIVE: begin
          state_d = ACTIVE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign active = (state_q == ACTIVE);
  assign mode   = mode_q;

endmodule

// File: tb/tb_dec_input_key.sv
// Directed bench for the serial access-key decoder: reset, both unlock
// codes, overlap restart, mismatch recovery, idle gaps and mid-key reset.
module tb_dec_input_key;

  logic clk;
  logic reset;
  logic input_key;
  logic valid_cmd;
  logic active;
  logic mode;

  int vectors;
  int miscompares;

  dec_input_key dut (
    .input_key (input_key),
    .valid_cmd (valid_cmd),
    .reset     (reset),
    .clk       (clk),
    .active    (active),
    .mode      (mode)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One qualified key bit; outputs are sampled 1 ns after the edge.
  task automatic drive_bit(input logic b);
    valid_cmd = 1'b1;
    input_key = b;
    @(posedge clk);
    #1;
    valid_cmd = 1'b0;
  endtask

  // Idle cycle with valid_cmd low and a possibly changing key bit.
  task automatic drive_gap(input logic b);
    valid_cmd = 1'b0;
    input_key = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    valid_cmd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    vectors++;
    if (active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_active: got %b expected 0", active);
    end
    vectors++;
    if (mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mode: got %b expected 0", mode);
    end
  endtask

  task automatic test_basic_unlock();
    logic [3:0] key;
    logic [2:0] extra;
    key   = 4'b1010;
    extra = 3'b101;
    pulse_reset();
    for (int i = 3; i >= 1; i--) begin
      drive_bit(key[i]);
      vectors++;
      if (active !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL basic_early_bit%0d: active=%b expected 0", 4 - i, active);
      end
    end
    drive_bit(key[0]);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_unlock: active=%b mode=%b expected 1 0", active, mode);
    end
    for (int i = 2; i >= 0; i--) begin
      drive_bit(extra[i]);
      vectors++;
      if (active !== 1'b1 || mode !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL basic_absorb%0d: active=%b mode=%b expected 1 0", 2 - i, active, mode);
      end
    end
  endtask

  task automatic test_extended_unlock();
    logic [3:0] key;
    key = 4'b1011;
    pulse_reset();
    for (int i = 3; i >= 0; i--) drive_bit(key[i]);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ext_unlock: active=%b mode=%b expected 1 1", active, mode);
    end
    // A 0 bit while active must not overwrite the latched mode.
    drive_bit(1'b0);
    drive_bit(1'b0);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ext_mode_frozen: active=%b mode=%b expected 1 1", active, mode);
    end
    pulse_reset();
    vectors++;
    if (active !== 1'b0 || mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ext_reset: active=%b mode=%b expected 0 0", active, mode);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] key;
    key = 5'b11010;
    pulse_reset();
    for (int i = 4; i >= 1; i--) drive_bit(key[i]);
    vectors++;
    if (active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overlap_early: active=%b expected 0", active);
    end
    drive_bit(key[0]);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overlap_unlock: active=%b mode=%b expected 1 0", active, mode);
    end
  endtask

  task automatic test_mismatch();
    logic [6:0] key;
    key = 7'b1001010;
    pulse_reset();
    for (int i = 6; i >= 1; i--) begin
      drive_bit(key[i]);
      vectors++;
      if (active !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mismatch_bit%0d: active=%b expected 0", 7 - i, active);
      end
    end
    drive_bit(key[0]);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mismatch_unlock: active=%b mode=%b expected 1 0", active, mode);
    end
  endtask

  task automatic test_gaps();
    pulse_reset();
    drive_bit(1'b1);
    drive_gap(1'b0);
    drive_gap(1'b1);
    drive_bit(1'b0);
    drive_gap(1'b0);
    drive_gap(1'b1);
    drive_gap(1'b0);
    drive_bit(1'b1);
    drive_gap(1'b0);
    drive_gap(1'b1);
    vectors++;
    if (active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL gap_pending: active=%b expected 0", active);
    end
    drive_bit(1'b1);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gap_unlock: active=%b mode=%b expected 1 1", active, mode);
    end
    drive_gap(1'b0);
    drive_gap(1'b1);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gap_hold: active=%b mode=%b expected 1 1", active, mode);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] key;
    key = 4'b1011;
    pulse_reset();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    // Reset coincides with a valid bit: reset must win.
    reset     = 1'b1;
    valid_cmd = 1'b1;
    input_key = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    valid_cmd = 1'b0;
    vectors++;
    if (active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_priority: active=%b expected 0", active);
    end
    drive_bit(1'b0);
    vectors++;
    if (active !== 1'b0 || mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_relock: active=%b mode=%b expected 0 0", active, mode);
    end
    for (int i = 3; i >= 0; i--) drive_bit(key[i]);
    vectors++;
    if (active !== 1'b1 || mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_reentry: active=%b mode=%b expected 1 1", active, mode);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    valid_cmd   = 1'b0;
    input_key   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_unlock();
    test_extended_unlock();
    test_overlap();
    test_mismatch();
    test_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dec_input_key.md
# dec_input_key

Serial access-key decoder at the front of the binary calculator controller. It samples one key bit per clock while `valid_cmd` is high and matches the stream against a fixed 4-bit unlock sequence. On a match it asserts `active` and latches the operating `mode` selected by the last key bit. Downstream controller logic starts processing commands only while `active` is high.

## Interface
Parameters: none (key codes are fixed constants in the shared package).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears the FSM and all outputs.
- `input_key`  in  1  current key bit; sampled only when `valid_cmd`=1.
- `valid_cmd`  in  1  qualifies `input_key` for the current cycle.
- `active`  out  1  registered; 1 once a valid key has been accepted.
- `mode`  out  1  registered; 0 = basic mode, 1 = extended mode; meaningful only when `active`=1.

Instantiation order is positional: (`input_key`, `valid_cmd`, `reset`, `clk`, `active`, `mode`).

## Operation
- Key sequences, applied MSB first, one bit per valid cycle:
  - `1010`: unlock in basic mode, `mode`=0.
  - `1011`: unlock in extended mode, `mode`=1.
- FSM states and the transition on a valid bit b (no change when `valid_cmd`=0):
  - IDLE: b=1 goes to S1; b=0 stays in IDLE.
  - S1: b=0 goes to S10; b=1 stays in S1 (overlap restart).
  - S10: b=1 goes to S101; b=0 goes to IDLE.
  - S101: b=0 goes to ACTIVE with `mode`=0; b=1 goes to ACTIVE with `mode`=1.
  - ACTIVE: absorbing. All further input is ignored and `mode` is frozen until `reset`.
- `active` = 1 exactly when the state is ACTIVE.
- `mode` is written only on the S101 to ACTIVE transition. Otherwise it holds, and it reads 0 whenever the block is not active.

## Timing
- Reset: when `reset`=1 at a rising edge, state goes to IDLE and `active`=0, `mode`=0. Reset has priority over `valid_cmd`.
- Reset asserted mid-sequence or while ACTIVE behaves the same as a reset at any other time: the decoder re-locks and the full key must be re-entered.
- Latency: the 4th key bit is sampled at edge N, and `active` and `mode` are valid after edge N. This is one cycle of registered latency with no combinational path from inputs to outputs.
- `valid_cmd` low cycles between bits are allowed. Bits need not be consecutive cycles.
- A bit that is held for several cycles with `valid_cmd` high counts once per cycle.

## Structure
- Shared package `calc_ctrl_pkg`:
  - State encoding constants: IDLE, S1, S10, S101, ACTIVE (3-bit).
  - `KEY_PREFIX` = 3'b101.
  - `MODE_BASIC` = 0 and `MODE_EXT` = 1.
- Single module with no sub-modules:
  - one state register;
  - one `mode` register;
  - next-state logic in a combinational block.

## Test plan
- Reset: `reset`=1 for 1 edge with `valid_cmd`=0 -> `active`=0, `mode`=0.
- Basic unlock: after reset, bits 1,0,1,0 with `valid_cmd`=1 -> `active`=1 and `mode`=0 after the 4th edge. Further bits 1,0,1 leave `active`=1 and `mode`=0.
- Extended unlock: bits 1,0,1,1 -> `active`=1, `mode`=1. Then `reset`=1 -> `active`=0, `mode`=0 on the next edge.
- Gaps and mismatch:
  - Bits 1,1,0,1,0 -> `active`=1, `mode`=0 (S1 overlap restart).
  - Bits 1,0,0,1,0,1,0 -> active only after the 7th bit.
  - Inserting `valid_cmd`=0 cycles with `input_key` toggling changes nothing.
- Reset mid-sequence: bits 1,0,1, then `reset`, then bit 0 -> `active` stays 0. The full key 1,0,1,1 then gives `active`=1, `mode`=1.
